// File: rtl/measurement_sequencer.sv
// -----------------------------------------------------------------------------
// measurement_sequencer
//
// Acquisition timing controller for the measurement path. Instead of
// producing a divided clock, it issues a one-cycle write strobe every
// cfg_rate+1 cycles. Each strobe targets one (sample slot, channel) pair.
// Channels are interleaved inside each slot. Capture is either single-shot
// or continuous (ring). Capture can optionally wait for a hardware trigger
// edge, and it can be aborted at any time.
//
// State table:
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_IDLE  | waiting for start; counters cleared; latched cfg retained
//   S_ARMED | capture accepted, waiting for a rising edge on trigger
//   S_ACQ   | strobing; rate_cnt paces strobes, addr/chan walk the buffer
//   S_DONE  | single-shot capture finished; ready high; waiting for start
//
// Ports:
//   aclk, areset    clock, asynchronous active-high reset
//   cfg_rate        divide ratio minus one (latched on accepted start)
//   cfg_nr          last sample index (latched on accepted start)
//   cfg_continuous  0 = single-shot, 1 = ring (latched on accepted start)
//   cfg_trig_en     wait for a trigger edge after start (latched)
//   start           level; acted on only in IDLE or DONE
//   abort           return to IDLE from any state; wins over start
//   trigger         synchronous trigger; rising edge starts ARMED capture
//   wr_en           one-cycle write strobe
//   wr_addr/wr_chan sample slot and channel for the current strobe
//   busy / ready    ARMED or ACQ / DONE
//   wrap_count      completed ring passes, saturating
//   status          {ready, busy, armed, continuous_q, ..., wr_addr}
// -----------------------------------------------------------------------------
module measurement_sequencer #(
    parameter int RATE_WIDTH   = 16,
    parameter int NR_WIDTH     = 10,
    parameter int NUM_CHANNELS = 1,
    parameter int CH_WIDTH     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [RATE_WIDTH-1:0] cfg_rate,
    input  logic [NR_WIDTH-1:0]   cfg_nr,
    input  logic                  cfg_continuous,
    input  logic                  cfg_trig_en,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  trigger,
    output logic                  wr_en,
    output logic [NR_WIDTH-1:0]   wr_addr,
    output logic [CH_WIDTH-1:0]   wr_chan,
    output logic                  busy,
    output logic                  ready,
    output logic [15:0]           wrap_count,
    output logic [31:0]           status
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_ACQ   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CH_WIDTH-1:0] LAST_CH = CH_WIDTH'(NUM_CHANNELS - 1);

    state_t                state_q,    state_d;
    logic [RATE_WIDTH-1:0] rate_q,     rate_d;
    logic [NR_WIDTH-1:0]   nr_q,       nr_d;
    logic                  cont_q,     cont_d;
    logic                  trig_en_q,  trig_en_d;
    logic [RATE_WIDTH-1:0] rate_cnt_q, rate_cnt_d;
    logic [NR_WIDTH-1:0]   addr_q,     addr_d;
    logic [CH_WIDTH-1:0]   chan_q,     chan_d;
    logic [15:0]           wrap_q,     wrap_d;
    logic                  trig_prev_q;
    logic                  strobe;
    logic                  trig_edge;

    // Strobe is decoded from registered state only, so no input reaches an
    // output combinationally. An abort takes effect on the next cycle, which
    // is IDLE and therefore never strobes.
    assign strobe    = (state_q == S_ACQ) && (rate_cnt_q == '0);
    assign trig_edge = trigger && !trig_prev_q;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= S_IDLE;
            rate_q      <= '0;
            nr_q        <= '0;
            cont_q      <= 1'b0;
            trig_en_q   <= 1'b0;
            rate_cnt_q  <= '0;
            addr_q      <= '0;
            chan_q      <= '0;
            wrap_q      <= '0;
            trig_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rate_q      <= rate_d;
            nr_q        <= nr_d;
            cont_q      <= cont_d;
            trig_en_q   <= trig_en_d;
            rate_cnt_q  <= rate_cnt_d;
            addr_q      <= addr_d;
            chan_q      <= chan_d;
            wrap_q      <= wrap_d;
            // The edge detector always tracks trigger. A level that is
            // already high on entry to ARMED therefore never counts as an edge.
            trig_prev_q <= trigger;
        end
    end

    always_comb begin
        state_d    = state_q;
        rate_d     = rate_q;
        nr_d       = nr_q;
        cont_d     = cont_q;
        trig_en_d  = trig_en_q;
        rate_cnt_d = rate_cnt_q;
        addr_d     = addr_q;
        chan_d     = chan_q;
        wrap_d     = wrap_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    rate_d     = cfg_rate;
                    nr_d       = cfg_nr;
                    cont_d     = cfg_continuous;
                    trig_en_d  = cfg_trig_en;
                    rate_cnt_d = '0;
                    addr_d     = '0;
                    chan_d     = '0;
                    wrap_d     = '0;
                    state_d    = cfg_trig_en ? S_ARMED : S_ACQ;
                end
            end

            S_ARMED: begin
                if (trig_edge) begin
                    state_d = S_ACQ;
                end
            end

            S_ACQ: begin
                rate_cnt_d = (rate_cnt_q == rate_q) ? '0 : rate_cnt_q + 1'b1;
                if (strobe) begin
                    if (chan_q != LAST_CH) begin
                        chan_d = chan_q + 1'b1;
                    end else if (addr_q != nr_q) begin
                        chan_d = '0;
                        addr_d = addr_q + 1'b1;
                    end else if (cont_q) begin
                        chan_d = '0;
                        addr_d = '0;
                        if (wrap_q != 16'hFFFF) begin
                            wrap_d = wrap_q + 16'd1;
                        end
                    end else begin
                        // Single-shot: the final slot stays visible on
                        // wr_addr while the sequencer waits in DONE.
                        state_d = S_DONE;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything above, including a start in the same
        // cycle. The configuration latched by the last accepted start is kept.
        if (abort) begin
            state_d    = S_IDLE;
            rate_d     = rate_q;
            nr_d       = nr_q;
            cont_d     = cont_q;
            trig_en_d  = trig_en_q;
            rate_cnt_d = '0;
            addr_d     = '0;
            chan_d     = '0;
            wrap_d     = '0;
        end
    end

    assign wr_en      = strobe;
    assign wr_addr    = addr_q;
    assign wr_chan    = chan_q;
    assign busy       = (state_q == S_ARMED) || (state_q == S_ACQ);
    assign ready      = (state_q == S_DONE);
    assign wrap_count = wrap_q;

    always_comb begin
        status               = '0;
        status[31]           = ready;
        status[30]           = busy;
        status[29]           = (state_q == S_ARMED);
        status[28]           = cont_q;
        status[NR_WIDTH-1:0] = addr_q;
    end

endmodule
